uart_tx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 55 +++++
 rtl/uart_baud_div.sv | 52 +++++
 rtl/uart_tx_frame.sv | 140 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity and FSM enums, baud select codes, divisor math.
package uart_pkg;

    localparam int unsigned DIV_W = 15;

    localparam logic [1:0] BAUD_115200 = 2'd0;
    localparam logic [1:0] BAUD_9600   = 2'd1;
    localparam logic [1:0] BAUD_4800   = 2'd2;
    localparam logic [1:0] BAUD_2400   = 2'd3;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    function automatic int unsigned baud_rate(input logic [1:0] sel);
        int unsigned rate;
        case (sel)
            BAUD_115200: rate = 115200;
            BAUD_9600:   rate = 9600;
            BAUD_4800:   rate = 4800;
            default:     rate = 2400;
        endcase
        return rate;
    endfunction

    // Rounded clk cycles per bit for the selected baud rate.
    function automatic logic [DIV_W-1:0] baud_divisor(input int unsigned clk_hz,
                                                      input logic [1:0]  sel);
        int unsigned rate;
        rate = baud_rate(sel);
        return DIV_W'((clk_hz + rate / 2) / rate);
    endfunction

    // Parity mode 3 is treated as "none".
    function automatic parity_t decode_parity(input logic [1:0] mode);
        parity_t p;
        case (mode)
            2'd1:    p = PAR_EVEN;
            2'd2:    p = PAR_ODD;
            default: p = PAR_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_div.sv
// Bit-period down-counter: restart loads DIV-1 for the chosen baud rate and
// latches the selection; tick is high for the one cycle the count is zero.
module uart_baud_div
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic [1:0] baud_sel,
    input  logic       enable,
    output logic       tick
);

    localparam logic [DIV_W-1:0] DIV_0 = baud_divisor(CLK_HZ, BAUD_115200);
    localparam logic [DIV_W-1:0] DIV_1 = baud_divisor(CLK_HZ, BAUD_9600);
    localparam logic [DIV_W-1:0] DIV_2 = baud_divisor(CLK_HZ, BAUD_4800);
    localparam logic [DIV_W-1:0] DIV_3 = baud_divisor(CLK_HZ, BAUD_2400);

    logic [1:0]       sel_q;
    logic [DIV_W-1:0] cnt_q;

    function automatic logic [DIV_W-1:0] reload_of(input logic [1:0] sel);
        logic [DIV_W-1:0] r;
        case (sel)
            BAUD_115200: r = DIV_0 - DIV_W'(1);
            BAUD_9600:   r = DIV_1 - DIV_W'(1);
            BAUD_4800:   r = DIV_2 - DIV_W'(1);
            default:     r = DIV_3 - DIV_W'(1);
        endcase
        return r;
    endfunction

    assign tick = enable && (cnt_q == '0);

    // Count down while enabled, reloading from the latched selection at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= BAUD_115200;
            cnt_q <= '0;
        end else if (restart) begin
            sel_q <= baud_sel;
            cnt_q <= reload_of(baud_sel);
        end else if (enable) begin
            if (cnt_q == '0) cnt_q <= reload_of(sel_q);
            else             cnt_q <= cnt_q - DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one word per valid/ready handshake, with per-frame baud,
// parity and stop-bit settings, and a one-cycle done pulse after each frame.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned DATA_BITS = 8
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    input  logic [1:0]           baud_sel,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 tx
);

    localparam int unsigned      IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 second_stop_q, second_stop_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    parity_t              par_q, par_d;
    logic                 two_stop_q, two_stop_d;
    logic                 tx_d, busy_d, ready_d, done_d;
    logic                 accept, bit_tick, parity_bit;

    // in_ready is high exactly while the FSM sits in IDLE.
    assign accept     = in_valid && in_ready;
    assign parity_bit = (^data_q) ^ (par_q == PAR_ODD);

    uart_baud_div #(
        .CLK_HZ (CLK_HZ)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (accept),
        .baud_sel (baud_sel),
        .enable   (busy),
        .tick     (bit_tick)
    );

    // Next-state, frame latching, and next-cycle output decode.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        second_stop_d = second_stop_q;
        data_d        = data_q;
        par_d         = par_q;
        two_stop_d    = two_stop_q;
        done_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d       = ST_START;
                    data_d        = in_data;
                    par_d         = decode_parity(parity_mode);
                    two_stop_d    = two_stop;
                    idx_d         = '0;
                    second_stop_d = 1'b0;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    if (idx_q == LAST_IDX)
                        state_d = (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
                    else
                        idx_d = idx_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (bit_tick) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (two_stop_q && !second_stop_q) begin
                        second_stop_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered
        // without adding a cycle of lag.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = data_q[idx_d];
            ST_PARITY: tx_d = parity_bit;
            default:   tx_d = 1'b1;
        endcase
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    // State, frame registers and registered outputs; reset aborts any frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            second_stop_q <= 1'b0;
            data_q        <= '0;
            par_q         <= PAR_NONE;
            two_stop_q    <= 1'b0;
            tx            <= 1'b1;
            in_ready      <= 1'b1;
            busy          <= 1'b0;
            tx_done       <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            second_stop_q <= second_stop_d;
            data_q        <= data_d;
            par_q         <= par_d;
            two_stop_q    <= two_stop_d;
            tx            <= tx_d;
            in_ready      <= ready_d;
            busy          <= busy_d;
            tx_done       <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: the driver queues the expected line
// waveform per accepted word; a monitor checks tx bit by bit and the frame end.
module tb_uart_tx_frame;

    localparam int CLK_HZ = 500_000;
    localparam int LIMIT  = 20000;

    typedef struct {
        int          div;
        int          nbits;
        logic [15:0] bits;
        longint      acc_cyc;
    } frame_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [1:0] baud_sel;
    logic [1:0] parity_mode;
    logic       two_stop;
    logic       busy;
    logic       tx_done;
    logic       tx;

    frame_t sb[$];
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     done_seen = 0;
    int     n_sent = 0;
    int     n_aborted = 0;
    bit     mon_busy = 0;
    bit     abort_expected = 0;

    uart_tx_frame #(
        .CLK_HZ    (CLK_HZ),
        .DATA_BITS (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .baud_sel    (baud_sel),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx          (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (tx_done === 1'b1) done_seen++;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, 1 or 2 stops.
    function automatic frame_t model(input logic [7:0] d, input logic [1:0] s,
                                     input logic [1:0] p, input logic t, input longint acc);
        frame_t f;
        int rate;
        int n;
        case (s)
            2'd0:    rate = 115200;
            2'd1:    rate = 9600;
            2'd2:    rate = 4800;
            default: rate = 2400;
        endcase
        f.div     = $rtoi(real'(CLK_HZ) / real'(rate) + 0.5);
        f.bits    = '0;
        f.acc_cyc = acc;
        n = 0;
        f.bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin f.bits[n] = d[i]; n++; end
        if (p == 2'd1 || p == 2'd2) begin
            f.bits[n] = (($countones(d) % 2) == 1) ^ (p == 2'd2);
            n++;
        end
        f.bits[n] = 1'b1; n++;
        if (t) begin f.bits[n] = 1'b1; n++; end
        f.nbits = n;
        return f;
    endfunction

    // Called just after a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [7:0] d, input logic [1:0] s, input logic [1:0] p,
                        input logic t, input bit keep_valid);
        int g = 0;
        in_data = d; baud_sel = s; parity_mode = p; two_stop = t; in_valid = 1'b1;
        while (in_ready !== 1'b1 && g < LIMIT) begin @(negedge clk); g++; end
        chk(g < LIMIT, "handshake_wait", g, LIMIT);
        if (g >= LIMIT) begin in_valid = 1'b0; return; end
        sb.push_back(model(d, s, p, t, cyc + 1));
        n_sent++;
        @(negedge clk);
        if (!keep_valid) begin
            in_valid    = 1'b0;
            in_data     = 8'($urandom);
            baud_sel    = 2'($urandom);
            parity_mode = 2'($urandom);
            two_stop    = 1'($urandom);
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || mon_busy) && g < LIMIT) begin @(negedge clk); g++; end
        chk(g < LIMIT, "drain_wait", g, LIMIT);
        @(negedge clk);
    endtask

    // Monitor: compare the serial line against the oldest queued frame.
    initial begin : monitor
        frame_t f;
        int     bad;
        int     g;
        bit     aborted;
        bit     ctl_bad;
        logic   bad_val;
        logic   exp_bit;
        longint start_cyc;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                start_cyc = cyc;
                chk(sb.size() != 0, "frame_expected", sb.size(), 1);
                if (sb.size() == 0) begin
                    g = 0;
                    while (tx === 1'b0 && g < LIMIT) begin @(negedge clk); g++; end
                end else begin
                    f = sb.pop_front();
                    mon_busy = 1;
                    chk(start_cyc == f.acc_cyc, "start_cycle", start_cyc, f.acc_cyc);
                    bad = -1; aborted = 0; ctl_bad = 0; bad_val = 1'b0;
                    for (int n = 0; n < f.nbits * f.div; n++) begin
                        if (n > 0) @(negedge clk);
                        if (rst_n !== 1'b1) begin aborted = 1; break; end
                        exp_bit = f.bits[n / f.div];
                        if (tx !== exp_bit && bad < 0) begin bad = n; bad_val = tx; end
                        if (busy !== 1'b1 || in_ready !== 1'b0 || tx_done !== 1'b0) ctl_bad = 1;
                    end
                    if (aborted) begin
                        chk(abort_expected, "abort_only_on_reset", 0, 1);
                        abort_expected = 0;
                        g = 0;
                        while (rst_n !== 1'b1 && g < LIMIT) begin @(negedge clk); g++; end
                    end else begin
                        exp_bit = (bad < 0) ? 1'b0 : f.bits[bad / f.div];
                        chk(bad < 0, $sformatf("bitstream_cycle%0d", bad), bad_val, exp_bit);
                        chk(!ctl_bad, "busy_ready_done_in_frame", ctl_bad, 0);
                        @(negedge clk);
                        chk(tx_done === 1'b1 && busy === 1'b0 && in_ready === 1'b1 && tx === 1'b1,
                            "end_of_frame_done_busy_ready_tx", {tx_done, busy, in_ready, tx}, 4'b1011);
                    end
                    mon_busy = 0;
                end
            end
        end
    end

    // Driver: directed frames, back-to-back pairs, random traffic, mid-frame reset.
    initial begin : driver
        in_valid = 1'b0; in_data = '0; baud_sel = '0; parity_mode = '0; two_stop = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk(tx === 1'b1,       "reset_tx",       tx,       1);
        chk(in_ready === 1'b1, "reset_in_ready", in_ready, 1);
        chk(busy === 1'b0,     "reset_busy",     busy,     0);
        chk(tx_done === 1'b0,  "reset_tx_done",  tx_done,  0);
        rst_n = 1'b1;
        @(negedge clk);

        send(8'h55, 2'd0, 2'd0, 1'b0, 1'b0); drain();
        send(8'h07, 2'd1, 2'd1, 1'b1, 1'b0); drain();
        send(8'h07, 2'd0, 2'd2, 1'b0, 1'b0); drain();
        send(8'hC3, 2'd2, 2'd1, 1'b0, 1'b1);
        send(8'h3C, 2'd0, 2'd2, 1'b1, 1'b0); drain();
        send(8'h81, 2'd1, 2'd3, 1'b1, 1'b0); drain();

        for (int i = 0; i < 20; i++) begin
            send(8'($urandom), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 30)) @(negedge clk);
            end
        end
        in_valid = 1'b0;
        drain();

        send(8'hA5, 2'd1, 2'd1, 1'b0, 1'b0);
        repeat (52 * 3) @(negedge clk);
        abort_expected = 1;
        #3 rst_n = 1'b0;
        #1;
        chk(tx === 1'b1,       "async_reset_tx",       tx,       1);
        chk(in_ready === 1'b1, "async_reset_in_ready", in_ready, 1);
        chk(busy === 1'b0,     "async_reset_busy",     busy,     0);
        chk(tx_done === 1'b0,  "async_reset_tx_done",  tx_done,  0);
        n_aborted++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drain();

        send(8'h5A, 2'd0, 2'd2, 1'b1, 1'b0); drain();

        chk(done_seen == n_sent - n_aborted, "tx_done_pulse_count", done_seen, n_sent - n_aborted);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
